// File: rtl/parity_pkg.sv
// Shared constants for the serial parity path: receive FSM encoding and parity sense.
// Used by serial_parity_checker and the upstream xor_gate parity generator.
package parity_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // XOR of the accumulated data parity, the received parity bit and the expected sense.
  function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic sense);
    return acc ^ par_bit ^ sense;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR register for the serial parity checker.
// Load seeds a new frame, toggle folds in a data bit, clear returns to zero between frames.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_tog,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  // Accumulator update; load has priority so a restart always reseeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_bit;
    end else if (i_tog) begin
      r_acc <= r_acc ^ i_bit;
    end else if (i_clr) begin
      r_acc <= 1'b0;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial receive stage: deserialises DATA_W bits LSB first, checks the trailing parity bit and
// holds the word in a one-slot valid/ready register. Optional macro: PARITY_ERR_CNT_EN.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ODD_PAR = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int              C_CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [C_CW-1:0] C_LAST  = C_CW'(DATA_W - 1);
  localparam logic            C_SENSE = (ODD_PAR != 0) ? PAR_ODD : PAR_EVEN;

  logic [1:0]        r_state;
  logic [C_CW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_perr;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              r_abort;

  logic w_accept;
  logic w_sof_acc;
  logic w_abort;
  logic w_take_data;
  logic w_take_par;
  logic w_hs;
  logic w_acc;

  // Accept/handshake qualifiers; an sof bit always restarts, aborting any frame in progress.
  always_comb begin
    w_accept    = in_valid & r_in_ready;
    w_sof_acc   = w_accept & in_sof;
    w_abort     = w_sof_acc & (r_state != ST_IDLE);
    w_take_data = w_accept & ~in_sof & (r_state == ST_DATA);
    w_take_par  = w_accept & ~in_sof & (r_state == ST_PARITY);
    w_hs        = r_out_valid & out_ready;
  end

  parity_accum u_accum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_take_par),
    .i_load (w_sof_acc),
    .i_tog  (w_take_data),
    .i_bit  (in_bit),
    .o_acc  (w_acc)
  );

  // Frame FSM, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {C_CW{1'b0}};
      r_shift <= {DATA_W{1'b0}};
    end else if (w_sof_acc) begin
      r_state <= ST_DATA;
      r_cnt   <= C_CW'(1);
      r_shift <= {{(DATA_W-1){1'b0}}, in_bit};
    end else if (w_accept) begin
      case (r_state)
        ST_DATA: begin
          r_shift[r_cnt] <= in_bit;
          r_cnt          <= r_cnt + C_CW'(1);
          r_state        <= (r_cnt == C_LAST) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          r_state <= ST_IDLE;
          r_cnt   <= {C_CW{1'b0}};
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {C_CW{1'b0}};
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Output slot: loaded by the parity bit, emptied by the downstream handshake.
  // No accept can coincide with a handshake because in_ready is low while the slot is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= {DATA_W{1'b0}};
      r_out_perr  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (w_take_par) begin
        r_out_data  <= r_shift;
        r_out_perr  <= parity_mismatch(w_acc, in_bit, C_SENSE);
        r_out_valid <= 1'b1;
        r_in_ready  <= 1'b0;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
      end else begin
        r_out_valid <= r_out_valid;
        r_in_ready  <= r_in_ready;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating count of delivered frames that carried a parity error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= {CNT_W{1'b0}};
    end else if (w_hs && r_out_perr && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

  assign in_ready    = r_in_ready;
  assign out_data    = r_out_data;
  assign out_perr    = r_out_perr;
  assign out_valid   = r_out_valid;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: directed frames with literal expectations plus a random
// phase, all checked every cycle against a queue-based frame model.
module tb_serial_parity_checker;

  localparam int DW      = 8;
  localparam int CW      = 2;
  localparam int ERR_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_perr;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          frame_abort;
  logic [CW-1:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  serial_parity_checker #(.DATA_W(DW), .ODD_PAR(0), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_perr    (out_perr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_abort (frame_abort),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the current frame is a queue of received bits.
  bit            mq[$];
  bit            model_ok = 1'b0;
  logic          m_valid, m_perr, m_abort;
  logic [DW-1:0] m_data;
  int            m_err;

  always @(posedge clk) begin : model
    bit acc, hs;
    int ones;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0; m_perr = 1'b0; m_abort = 1'b0; m_data = '0; m_err = 0;
      model_ok = 1'b1;
    end else begin
      acc = in_valid && !m_valid;
      hs  = m_valid && out_ready;
      m_abort = 1'b0;
      if (hs) begin
`ifdef PARITY_ERR_CNT_EN
        if (m_perr && m_err < ERR_MAX) m_err++;
`endif
        m_valid = 1'b0;
      end
      if (acc) begin
        if (in_sof) begin
          if (mq.size() > 0) m_abort = 1'b1;
          mq.delete();
          mq.push_back(in_bit);
        end else if (mq.size() > 0) begin
          mq.push_back(in_bit);
          if (mq.size() == DW + 1) begin
            m_data = '0;
            ones = 0;
            for (int i = 0; i <= DW; i++) begin
              if (i < DW) m_data = m_data | (DW'(mq[i]) << i);
              ones += int'(mq[i]);
            end
            m_perr  = (ones % 2) != 0;
            m_valid = 1'b1;
            mq.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready",    32'(in_ready),    32'(!m_valid));
      chk("out_valid",   32'(out_valid),   32'(m_valid));
      chk("out_data",    32'(out_data),    32'(m_data));
      chk("out_perr",    32'(out_perr),    32'(m_perr));
      chk("frame_abort", 32'(frame_abort), 32'(m_abort));
      chk("err_cnt",     32'(err_cnt),     32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    int  waited;
    logic ok;
    in_valid = 1'b1; in_bit = b; in_sof = sof;
    waited = 0;
    do begin
      ok = in_ready;
      tick();
      waited++;
    end while (!ok && waited < 50);
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic par);
    for (int i = 0; i < DW; i++) send_bit(w[i], (i == 0) ? 1'b1 : 1'b0);
    send_bit(par, 1'b0);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_out_data",  32'(out_data),    32'd0);
    chk("rst_out_perr",  32'(out_perr),    32'd0);
    chk("rst_abort",     32'(frame_abort), 32'd0);
    chk("rst_err_cnt",   32'(err_cnt),     32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_err[5];
    tick();
    do_reset();

    // 1: good frame 0xA5
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'hA5);
    chk("t1_perr",  32'(out_perr),  32'd0);
    tick();
    chk("t1_err", 32'(err_cnt), 32'd0);

    // 2: same frame, bad parity
    send_frame(8'hA5, 1'b1);
    chk("t2_perr", 32'(out_perr), 32'd1);
    tick();
    chk("t2_in_ready", 32'(in_ready), 32'd1);
`ifdef PARITY_ERR_CNT_EN
    chk("t2_err", 32'(err_cnt), 32'd1);
`else
    chk("t2_err", 32'(err_cnt), 32'd0);
`endif

    // 3: abort after three bits, then 0xFF
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("t3_abort", 32'(frame_abort), 32'd1);
    for (int i = 1; i < DW; i++) send_bit(1'b1, 1'b0);
    chk("t3_no_output", 32'(out_valid), 32'd0);
    send_bit(1'b0, 1'b0);
    idle();
    chk("t3_data", 32'(out_data), 32'hFF);
    chk("t3_perr", 32'(out_perr), 32'd0);
    tick();

    // 4: backpressure holds the slot
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_data",     32'(out_data), 32'h3C);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t4_valid_clr", 32'(out_valid), 32'd0);
    chk("t4_in_ready1", 32'(in_ready),  32'd1);

    // 5: saturation, then reset mid-frame and with a full slot
    do_reset();
`ifdef PARITY_ERR_CNT_EN
    exp_err = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    exp_err = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0);
      tick();
      chk("t5_err", 32'(err_cnt), 32'(exp_err[k]));
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0) ? 1'b1 : 1'b0);
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0);
    chk("t5_post_rst_data", 32'(out_data), 32'h5A);
    tick();

    // Random phase
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      in_sof    = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
